// File: rtl/m_wb_initiator_pkg.sv
// Shared types for the Wishbone single-transfer initiator: FSM encoding and latency saturation helper.
// No logic of its own; imported by the top and by the counter.
package m_wb_initiator_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUS  = 1'b1
   } state_t;

   localparam int LATW_DEF    = 8;
   localparam int TIMEOUT_DEF = 64;

   // Largest value an unsigned w-bit latency field can hold.
   function automatic int lat_max(input int w);
      return (1 << w) - 1;
   endfunction

   localparam int LAT_SAT_DEF = lat_max(LATW_DEF);

endpackage

// File: rtl/m_wb_initiator_cnt.sv
// Loadable saturating STB-cycle counter with an ==TIMEOUT flag; one-cycle update, no backpressure.
// M_WB_INITIATOR_LATCNT_EN exposes the count as latency; otherwise lat is 0 and the count only feeds the flag.
module m_wb_initiator_cnt
   import m_wb_initiator_pkg::*;
#(
   parameter int LATW    = LATW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            inc,
   output logic [LATW-1:0] lat,
   output logic            at_timeout
);

   localparam logic [LATW-1:0] TMO = LATW'(TIMEOUT);

`ifdef M_WB_INITIATOR_LATCNT_EN
   localparam logic [LATW-1:0] CAP = LATW'(lat_max(LATW));
`else
   // Nothing past TIMEOUT is ever observed, so the count can stop there.
   localparam logic [LATW-1:0] CAP = TMO;
`endif

   logic [LATW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LATW'(1);
      end else if (inc && (cnt != CAP)) begin
         cnt <= cnt + LATW'(1);
      end
   end

   assign at_timeout = (cnt == TMO);

`ifdef M_WB_INITIATOR_LATCNT_EN
   assign lat = cnt;
`else
   assign lat = '0;
`endif

endmodule

// File: rtl/m_wb_initiator.sv
// Wishbone classic single-transfer initiator; STB held until ACK_I or TIMEOUT, response one edge later as a pulse.
// One command in flight, cmd_ready low during BUS; rsp has no backpressure. Latency field needs M_WB_INITIATOR_LATCNT_EN.
module m_wb_initiator
   import m_wb_initiator_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int LATW    = LATW_DEF
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [31:0]     cmd_adr,
   input  logic [31:0]     cmd_dat,
   input  logic [3:0]      cmd_sel,
   output logic            rsp_valid,
   output logic [31:0]     rsp_dat,
   output logic            rsp_err,
   output logic [LATW-1:0] rsp_lat,
   output logic            CYC_O,
   output logic            STB_O,
   output logic            WE_O,
   output logic [31:0]     ADR_O,
   output logic [31:0]     DAT_O,
   output logic [3:0]      SEL_O,
   input  logic            ACK_I,
   input  logic [31:0]     DAT_I
);

   state_t state, state_nx;

   logic [LATW-1:0] cnt_lat;
   logic            at_timeout;
   logic            cnt_load;
   logic            cnt_inc;

   logic            cyc_nx;
   logic            stb_nx;
   logic            we_nx;
   logic [31:0]     adr_nx;
   logic [31:0]     dat_nx;
   logic [3:0]      sel_nx;
   logic            rsp_valid_nx;
   logic [31:0]     rsp_dat_nx;
   logic            rsp_err_nx;
   logic [LATW-1:0] rsp_lat_nx;

   // cmd_ready is a pure decode of the state flop, so it is registered too.
   assign cmd_ready = (state == S_IDLE);
   assign cnt_load  = (state == S_IDLE) && cmd_valid;
   assign cnt_inc   = (state == S_BUS);

   m_wb_initiator_cnt #(
      .LATW    (LATW),
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk        (CLK_I),
      .rst        (RST_I),
      .load       (cnt_load),
      .inc        (cnt_inc),
      .lat        (cnt_lat),
      .at_timeout (at_timeout)
   );

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nx = S_BUS;
         S_BUS:   if (ACK_I || at_timeout) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cyc_nx       = CYC_O;
      stb_nx       = STB_O;
      we_nx        = WE_O;
      adr_nx       = ADR_O;
      dat_nx       = DAT_O;
      sel_nx       = SEL_O;
      rsp_valid_nx = 1'b0;
      rsp_dat_nx   = rsp_dat;
      rsp_err_nx   = rsp_err;
      rsp_lat_nx   = rsp_lat;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               cyc_nx = 1'b1;
               stb_nx = 1'b1;
               we_nx  = cmd_we;
               adr_nx = cmd_adr;
               dat_nx = cmd_dat;
               sel_nx = cmd_sel;
            end
         end
         S_BUS: begin
            // ACK on the timeout edge still counts as a normal completion.
            if (ACK_I) begin
               cyc_nx       = 1'b0;
               stb_nx       = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_dat_nx   = WE_O ? 32'h0 : DAT_I;
               rsp_err_nx   = 1'b0;
               rsp_lat_nx   = cnt_lat;
            end else if (at_timeout) begin
               cyc_nx       = 1'b0;
               stb_nx       = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_dat_nx   = 32'h0;
               rsp_err_nx   = 1'b1;
               rsp_lat_nx   = cnt_lat;
            end
         end
         default: begin
            cyc_nx = 1'b0;
            stb_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         CYC_O     <= 1'b0;
         STB_O     <= 1'b0;
         WE_O      <= 1'b0;
         ADR_O     <= 32'h0;
         DAT_O     <= 32'h0;
         SEL_O     <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_dat   <= 32'h0;
         rsp_err   <= 1'b0;
         rsp_lat   <= '0;
      end else begin
         CYC_O     <= cyc_nx;
         STB_O     <= stb_nx;
         WE_O      <= we_nx;
         ADR_O     <= adr_nx;
         DAT_O     <= dat_nx;
         SEL_O     <= sel_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_dat   <= rsp_dat_nx;
         rsp_err   <= rsp_err_nx;
         rsp_lat   <= rsp_lat_nx;
      end
   end

endmodule

// File: tb/tb_m_wb_initiator.sv
// Bench for m_wb_initiator: programmable-latency responder, transaction-level model and per-cycle compare.
module tb_m_wb_initiator;

   localparam int TIMEOUT = 64;
   localparam int LATW    = 8;

   logic            CLK_I = 1'b0;
   logic            RST_I;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_we;
   logic [31:0]     cmd_adr;
   logic [31:0]     cmd_dat;
   logic [3:0]      cmd_sel;
   logic            rsp_valid;
   logic [31:0]     rsp_dat;
   logic            rsp_err;
   logic [LATW-1:0] rsp_lat;
   logic            CYC_O, STB_O, WE_O;
   logic [31:0]     ADR_O, DAT_O;
   logic [3:0]      SEL_O;
   logic            ACK_I;
   logic [31:0]     DAT_I;

   m_wb_initiator #(.TIMEOUT(TIMEOUT), .LATW(LATW)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .rsp_lat(rsp_lat),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
      .SEL_O(SEL_O), .ACK_I(ACK_I), .DAT_I(DAT_I)
   );

   always #5 CLK_I = ~CLK_I;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int elat(input int n);
`ifdef M_WB_INITIATOR_LATCNT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   // Responder: words at 0x00-0xFF (8 aliased words), latency register at 0x80, unmapped above.
   logic [31:0] rmem [8] = '{default: 32'h0};
   logic [31:0] rlat_reg = 32'h0;
   logic [31:0] age      = 32'h0;
   logic        ack_stray = 1'b0;

   assign ACK_I = (STB_O && (ADR_O < 32'h100) && (age == rlat_reg)) || ack_stray;
   assign DAT_I = (ADR_O == 32'h80) ? rlat_reg : rmem[ADR_O[4:2]];

   always @(posedge CLK_I) begin
      if (RST_I || !STB_O || ACK_I) age <= 32'h0;
      else                          age <= age + 32'h1;
      if (STB_O && ACK_I && WE_O) begin
         if (ADR_O == 32'h80) rlat_reg <= DAT_O;
         else begin
            for (int b = 0; b < 4; b++)
               if (SEL_O[b]) rmem[ADR_O[4:2]][8*b +: 8] <= DAT_O[8*b +: 8];
         end
      end
   end

   always @(posedge CLK_I) cyc <= cyc + 1;

   // Transaction model: expected outcome of each accepted command.
   typedef struct {
      logic [31:0] dat;
      logic        err;
      int          stb;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mmem [8] = '{default: 32'h0};
   logic [31:0] mlat = 32'h0;
   logic        cur_we;
   logic [31:0] cur_adr, cur_dat;
   logic [3:0]  cur_sel;

   task automatic model_accept(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel);
      exp_t e;
      cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
      if ((adr < 32'h100) && (mlat < 32'(TIMEOUT))) begin
         e.err = 1'b0;
         e.stb = int'(mlat) + 1;
         e.dat = we ? 32'h0 : ((adr == 32'h80) ? mlat : mmem[adr[4:2]]);
         if (we) begin
            if (adr == 32'h80) mlat = dat;
            else
               for (int b = 0; b < 4; b++)
                  if (sel[b]) mmem[adr[4:2]][8*b +: 8] = dat[8*b +: 8];
         end
      end else begin
         e.err = 1'b1;
         e.stb = TIMEOUT;
         e.dat = 32'h0;
      end
      exp_q.push_back(e);
   endtask

   int          stb_run = 0;
   logic        prev_rv = 1'b0;
   logic [31:0] last_dat;
   logic        last_err;
   int          last_lat;
   int          last_stb;

   always @(negedge CLK_I) begin
      exp_t e;
      if (STB_O) begin
         stb_run++;
         chk("bus_adr", ADR_O, cur_adr);
         chk("bus_dat", DAT_O, cur_dat);
         chk("bus_we",  32'(WE_O), 32'(cur_we));
         chk("bus_sel", 32'(SEL_O), 32'(cur_sel));
      end
      chk("cyc_eq_stb", 32'(CYC_O), 32'(STB_O));
      if (rsp_valid) begin
         chk("rsp_one_cycle", 32'(prev_rv), 32'h0);
         chk("rsp_cyc_low", 32'(CYC_O), 32'h0);
         chk("rsp_pending", 32'(exp_q.size() > 0), 32'h1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_dat", rsp_dat, e.dat);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_lat", 32'(rsp_lat), 32'(elat(e.stb)));
            chk("stb_cycles", 32'(stb_run), 32'(e.stb));
         end
         last_dat = rsp_dat;
         last_err = rsp_err;
         last_lat = int'(rsp_lat);
         last_stb = stb_run;
         stb_run  = 0;
      end else if (!STB_O) begin
         stb_run = 0;
      end
      prev_rv = rsp_valid;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit hold, output int acc_cyc);
      bit acc   = 1'b0;
      int guard = 0;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      while (!acc) begin
         acc = cmd_ready;
         if (acc) model_accept(we, adr, dat, sel);
         @(posedge CLK_I);
         if (!acc) begin
            guard++;
            if (guard > 200) begin
               chk("accept_timeout", 32'(guard), 32'h0);
               break;
            end
            @(negedge CLK_I);
         end
      end
      acc_cyc = cyc;
      @(negedge CLK_I);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge CLK_I);
         guard++;
      end
      chk("rsp_wait", 32'(exp_q.size()), 32'h0);
      @(negedge CLK_I);
      chk("rsp_pulse_end", 32'(rsp_valid), 32'h0);
   endtask

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
      int c;
      issue(we, adr, dat, sel, 1'b0, c);
      wait_done();
   endtask

   initial begin
      int c [4];
      RST_I = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
      cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
      cur_we = 1'b0; cur_adr = 32'h0; cur_dat = 32'h0; cur_sel = 4'h0;
      repeat (2) @(posedge CLK_I);
      @(negedge CLK_I);
      chk("rst_cyc", 32'(CYC_O), 32'h0);
      chk("rst_stb", 32'(STB_O), 32'h0);
      chk("rst_we", 32'(WE_O), 32'h0);
      chk("rst_adr", ADR_O, 32'h0);
      chk("rst_dato", DAT_O, 32'h0);
      chk("rst_sel", 32'(SEL_O), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_dat", rsp_dat, 32'h0);
      chk("rst_rsp_lat", 32'(rsp_lat), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      RST_I = 1'b0;
      @(negedge CLK_I);

      // Zero-latency write
      issue(1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, c[0]);
      chk("t1_dato", DAT_O, 32'h12345678);
      chk("t1_we", 32'(WE_O), 32'h1);
      chk("t1_cmd_ready_bus", 32'(cmd_ready), 32'h0);
      wait_done();
      chk("t1_lat", 32'(last_lat), 32'(elat(1)));
      chk("t1_err", 32'(last_err), 32'h0);
      chk("t1_stb", 32'(last_stb), 32'h1);

      // Programmed read latency 5, byte-select merge
      xfer(1'b1, 32'h80, 32'h5, 4'hF);
      xfer(1'b1, 32'h08, 32'hCAFEF00D, 4'hF);
      xfer(1'b1, 32'h08, 32'h11223344, 4'b0101);
      xfer(1'b0, 32'h08, 32'h0, 4'hF);
      chk("t2_stb", 32'(last_stb), 32'h6);
      chk("t2_lat", 32'(last_lat), 32'(elat(6)));
      chk("t2_dat", last_dat, 32'hCA22F044);
      xfer(1'b1, 32'h80, 32'h0, 4'hF);

      // Unmapped read times out
      xfer(1'b0, 32'h1000, 32'h0, 4'hF);
      chk("t3_err", 32'(last_err), 32'h1);
      chk("t3_dat", last_dat, 32'h0);
      chk("t3_stb", 32'(last_stb), 32'(TIMEOUT));
      chk("t3_lat", 32'(last_lat), 32'(elat(TIMEOUT)));

      // cmd_valid held across four commands
      issue(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b1, c[0]);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, c[1]);
      issue(1'b1, 32'h14, 32'h5A5A0001, 4'hF, 1'b1, c[2]);
      issue(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, c[3]);
      wait_done();
      chk("t4_gap1", 32'(c[1] - c[0]), 32'h2);
      chk("t4_gap2", 32'(c[2] - c[1]), 32'h2);
      chk("t4_gap3", 32'(c[3] - c[2]), 32'h2);
      chk("t4_last_dat", last_dat, 32'h5A5A0001);

      // Reset in the third BUS cycle
      xfer(1'b1, 32'h80, 32'd10, 4'hF);
      issue(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, c[0]);
      @(negedge CLK_I);
      @(negedge CLK_I);
      RST_I = 1'b1;
      exp_q.delete();
      @(negedge CLK_I);
      RST_I = 1'b0;
      chk("t5_cyc", 32'(CYC_O), 32'h0);
      chk("t5_stb", 32'(STB_O), 32'h0);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t5_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("t5_adr", ADR_O, 32'h0);
      repeat (15) @(negedge CLK_I);
      chk("t5_still_idle", 32'(STB_O), 32'h0);
      xfer(1'b1, 32'h80, 32'h0, 4'hF);
      chk("t5_restore_stb", 32'(last_stb), 32'd11);

      // Stray ACK while idle, then ACK exactly on the timeout edge
      ack_stray = 1'b1;
      @(negedge CLK_I);
      ack_stray = 1'b0;
      chk("t6_stray_cyc", 32'(CYC_O), 32'h0);
      @(negedge CLK_I);
      chk("t6_stray_rsp", 32'(rsp_valid), 32'h0);
      xfer(1'b1, 32'h80, 32'd63, 4'hF);
      xfer(1'b0, 32'h0C, 32'h0, 4'hF);
      chk("t6_edge_err", 32'(last_err), 32'h0);
      chk("t6_edge_stb", 32'(last_stb), 32'(TIMEOUT));
      chk("t6_edge_lat", 32'(last_lat), 32'(elat(TIMEOUT)));
      xfer(1'b1, 32'h80, 32'd64, 4'hF);
      xfer(1'b0, 32'h0C, 32'h0, 4'hF);
      chk("t6_slow_err", 32'(last_err), 32'h1);
      chk("t6_slow_dat", last_dat, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
